// File: rtl/bram_8192x2.sv
// 8192 x 2 true dual-port block RAM: shared clock, per-bit write masks,
// read-first registered outputs with asynchronous clear.
module bram_8192x2 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE0,
  input  logic [12:0] A0,
  input  logic [1:0]  D0,
  input  logic        WE0,
  input  logic [1:0]  WEM0,
  output logic [1:0]  Q0,
  input  logic        CE1,
  input  logic [12:0] A1,
  input  logic [1:0]  D1,
  input  logic        WE1,
  input  logic [1:0]  WEM1,
  output logic [1:0]  Q1
);

  localparam int DEPTH = 8192;
  localparam int VEC_W = 2;

  logic [VEC_W-1:0] mem [0:DEPTH-1];

  // Port 1 is written after port 0 so it wins on bits both ports mask on.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < VEC_W; i++) begin
        if (CE0 && WE0 && WEM0[i]) mem[A0][i] <= D0[i];
        if (CE1 && WE1 && WEM1[i]) mem[A1][i] <= D1[i];
      end
    end
  end

  // Read-first: the RHS samples mem before this edge's writes land.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q0 <= '0;
      Q1 <= '0;
    end else begin
      if (CE0) Q0 <= mem[A0];
      if (CE1) Q1 <= mem[A1];
    end
  end

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (CE0 && CE1 && (WE0 || WE1) && (A0 == A1)) begin
      $display("address conflict in %m");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_bram_8192x2.sv
// Directed bench for bram_8192x2: masks, read-first, CE hold, dual-port
// access and asynchronous reset, checked with immediate assertions.
module tb_bram_8192x2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE0, WE0, CE1, WE1;
  logic [12:0] A0, A1;
  logic [1:0]  D0, WEM0, D1, WEM1;
  logic [1:0]  Q0, Q1;

  int checks = 0;
  int failures = 0;

  bram_8192x2 dut (
    .CLK(CLK), .RST(RST),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .Q0(Q0),
    .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic p0(input logic ce, input logic we, input logic [12:0] a,
                    input logic [1:0] d, input logic [1:0] m);
    CE0 = ce; WE0 = we; A0 = a; D0 = d; WEM0 = m;
  endtask

  task automatic p1(input logic ce, input logic we, input logic [12:0] a,
                    input logic [1:0] d, input logic [1:0] m);
    CE1 = ce; WE1 = we; A1 = a; D1 = d; WEM1 = m;
  endtask

  initial begin
    RST = 1'b1;
    p0(0, 0, 13'd0, 2'b00, 2'b00);
    p1(0, 0, 13'd0, 2'b00, 2'b00);
    #2;
    chk("reset_q0", Q0, 2'b00);
    chk("reset_q1", Q1, 2'b00);
    tick();
    RST = 1'b0;
    tick();

    // basic write on port 0, read on port 1 at top and bottom addresses
    p0(1, 1, 13'h1FFF, 2'b10, 2'b11); tick();
    p0(0, 0, 13'h0, 2'b00, 2'b00);
    p1(1, 0, 13'h1FFF, 2'b00, 2'b00); tick();
    chk("rd_1fff", Q1, 2'b10);
    p1(0, 0, 13'h0, 2'b00, 2'b00);
    p0(1, 1, 13'h0, 2'b01, 2'b11); tick();
    p0(0, 0, 13'h0, 2'b00, 2'b00);
    p1(1, 0, 13'h0, 2'b00, 2'b00); tick();
    chk("rd_0", Q1, 2'b01);
    p1(0, 0, 13'h0, 2'b00, 2'b00);

    // bit mask on address 7
    p0(1, 1, 13'd7, 2'b11, 2'b11); tick();
    p0(1, 1, 13'd7, 2'b00, 2'b01); tick();
    chk("mask_rf_old", Q0, 2'b11);
    p0(1, 0, 13'd7, 2'b00, 2'b00); tick();
    chk("mask_01", Q0, 2'b10);
    p0(1, 1, 13'd7, 2'b01, 2'b00); tick();
    chk("mask_00_read", Q0, 2'b10);
    p0(1, 0, 13'd7, 2'b00, 2'b00); tick();
    chk("mask_00_keep", Q0, 2'b10);

    // read-first on the writing port
    p0(1, 1, 13'd3, 2'b01, 2'b11); tick();
    p0(1, 1, 13'd3, 2'b10, 2'b11); tick();
    chk("rf_old", Q0, 2'b01);
    p0(1, 0, 13'd3, 2'b00, 2'b00); tick();
    chk("rf_new", Q0, 2'b10);

    // CE hold: disabled port 1 keeps Q1 and its writes are dropped
    p0(1, 1, 13'd9, 2'b11, 2'b11); tick();
    p0(0, 0, 13'd0, 2'b00, 2'b00);
    p1(1, 0, 13'd9, 2'b00, 2'b00); tick();
    chk("ce_pre", Q1, 2'b11);
    for (int k = 0; k < 4; k++) begin
      p1(0, 1, (k == 0) ? 13'd9 : 13'd40 + 13'(k), 2'b00, 2'b11); tick();
      chk("ce_hold", Q1, 2'b11);
    end
    p1(1, 0, 13'd9, 2'b00, 2'b00); tick();
    chk("ce_nowrite", Q1, 2'b11);

    // dual independent writes, cross read-back
    p0(1, 1, 13'd100, 2'b01, 2'b11);
    p1(1, 1, 13'd200, 2'b10, 2'b11); tick();
    p0(1, 0, 13'd200, 2'b00, 2'b00);
    p1(1, 0, 13'd100, 2'b00, 2'b00); tick();
    chk("dual_q0", Q0, 2'b10);
    chk("dual_q1", Q1, 2'b01);
    // port 1 masked write clears only bit 1 of mem[200]
    p0(0, 0, 13'd0, 2'b00, 2'b00);
    p1(1, 1, 13'd200, 2'b01, 2'b10); tick();
    p1(1, 0, 13'd200, 2'b00, 2'b00); tick();
    chk("p1_mask", Q1, 2'b00);

    // asynchronous reset mid-cycle, memory survives, writes suppressed
    p1(1, 1, 13'd5, 2'b10, 2'b11); tick();
    p0(1, 0, 13'd9, 2'b00, 2'b00);
    p1(1, 0, 13'd5, 2'b00, 2'b00); tick();
    chk("pre_rst_q0", Q0, 2'b11);
    chk("pre_rst_q1", Q1, 2'b10);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_q0", Q0, 2'b00);
    chk("async_rst_q1", Q1, 2'b00);
    p0(1, 1, 13'd5, 2'b01, 2'b11);
    p1(0, 0, 13'd0, 2'b00, 2'b00);
    tick();
    chk("rst_hold_q0", Q0, 2'b00);
    RST = 1'b0;
    p0(1, 0, 13'd5, 2'b00, 2'b00); tick();
    chk("post_rst_mem", Q0, 2'b10);
    p0(0, 0, 13'd0, 2'b00, 2'b00); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
